// File: rtl/crc_slot_scheduler.sv
// crc_slot_scheduler: round-robin owner of the shared serial CRC slot.
// Optional macro SCHED_ABORT_EN: dropping Req of the winner aborts its frame.
module crc_slot_scheduler #(
  parameter int NREQ       = 4,
  parameter int IW         = 2,
  parameter int FRAME_BITS = 20,
  parameter int CW         = 5,
  parameter int GAP        = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            En,
  input  logic [NREQ-1:0] Req,
  output logic [NREQ-1:0] Grant,
  output logic            Busy,
  output logic [CW-1:0]   BitIdx,
  output logic            FrameStart,
  output logic            FrameEnd,
  output logic            Aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam state_t        S_DONE   = (GAP == 0) ? S_IDLE : S_GAP;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [CW-1:0]   r_bit, w_bit_nxt;
  logic [CW-1:0]   r_gap, w_gap_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [IW-1:0]   r_win, w_win_nxt;
  logic [IW-1:0]   w_pick;
  logic [NREQ-1:0] w_onehot;
  logic            w_bit_end;
  logic            w_gap_end;
  logic            w_send;
`ifdef SCHED_ABORT_EN
  logic            r_abort, w_abort_nxt;
  logic            w_drop;
`endif

  // Scan from the requester after the last served one, wrapping mod NREQ.
  function automatic logic [IW-1:0] f_pick(
    input logic [IW-1:0]   last,
    input logic [NREQ-1:0] req
  );
    logic [IW-1:0] p;
    int            k;
    p = last;
    for (int i = NREQ; i >= 1; i--) begin
      k = (int'(last) + i) % NREQ;
      if (req[k]) p = IW'(k);
    end
    return p;
  endfunction

  assign w_pick    = f_pick(r_last, Req);
  assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_bit_end = (r_bit == LAST_BIT);
  assign w_gap_end = (r_gap == LAST_GAP);
  assign w_send    = (r_state == S_SEND);
`ifdef SCHED_ABORT_EN
  assign w_drop    = w_send && !Req[r_win] && !(En && w_bit_end);
`endif

  // Next-state and next-register values; everything holds by default.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_last_nxt  = r_last;
    w_win_nxt   = r_win;
`ifdef SCHED_ABORT_EN
    w_abort_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|Req) begin
          w_win_nxt   = w_pick;
          w_grant_nxt = w_onehot;
          w_bit_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
`ifdef SCHED_ABORT_EN
        if (w_drop) begin
          w_grant_nxt = '0;
          w_bit_nxt   = '0;
          w_gap_nxt   = '0;
          w_abort_nxt = 1'b1;
          w_last_nxt  = r_win;
          w_state_nxt = S_DONE;
        end else
`endif
        if (En) begin
          if (w_bit_end) begin
            w_grant_nxt = '0;
            w_bit_nxt   = '0;
            w_gap_nxt   = '0;
            w_last_nxt  = r_win;
            w_state_nxt = S_DONE;
          end else begin
            w_bit_nxt = r_bit + CW'(1);
          end
        end
      end
      S_GAP: begin
        if (En) begin
          if (w_gap_end) begin
            w_gap_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt = r_gap + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_bit_nxt   = '0;
        w_gap_nxt   = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_last  <= LAST_RST;
      r_win   <= '0;
`ifdef SCHED_ABORT_EN
      r_abort <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_bit   <= w_bit_nxt;
      r_gap   <= w_gap_nxt;
      r_last  <= w_last_nxt;
      r_win   <= w_win_nxt;
`ifdef SCHED_ABORT_EN
      r_abort <= w_abort_nxt;
`endif
    end
  end

  assign Grant      = r_grant;
  assign Busy       = (r_state != S_IDLE);
  assign BitIdx     = r_bit;
  assign FrameStart = w_send && En && (r_bit == '0);
  assign FrameEnd   = w_send && En && w_bit_end;
`ifdef SCHED_ABORT_EN
  assign Aborted    = r_abort;
`else
  assign Aborted    = 1'b0;
`endif

endmodule

// File: tb/tb_crc_slot_scheduler.sv
// tb_crc_slot_scheduler: directed stimulus with an event scoreboard.
// Expected grant/end/fall/abort events are queued and matched by a monitor.
module tb_crc_slot_scheduler;

  localparam int FB = 20;

  localparam int K_GRANT = 0;
  localparam int K_END   = 1;
  localparam int K_FALL  = 2;
  localparam int K_ABORT = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b1;
  logic [3:0] Req = 4'b0;
  logic [3:0] Grant;
  logic       Busy;
  logic [4:0] BitIdx;
  logic       FrameStart;
  logic       FrameEnd;
  logic       Aborted;

  crc_slot_scheduler dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .En         (En),
    .Req        (Req),
    .Grant      (Grant),
    .Busy       (Busy),
    .BitIdx     (BitIdx),
    .FrameStart (FrameStart),
    .FrameEnd   (FrameEnd),
    .Aborted    (Aborted)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  bit en_alt = 1'b0;
  int en_base = 0;

  always @(posedge Clk) begin
    #1;
    En = !en_alt || (((cyc - en_base) % 2) == 1);
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  task automatic push(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic frame(input int g, input int gc, input bit full);
    push(K_GRANT, g, gc);
    if (full) begin
      push(K_END, FB - 1, gc + FB - 1);
      push(K_FALL, 0, gc + FB);
    end
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected event: kind %0d val %0d at cycle %0d, none expected",
               k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event kind", k, e.kind);
      chk("event value", v, e.val);
      chk("event cycle", cyc, e.cyc);
    end
  endtask

  logic [3:0] prev_g = 4'b0;
  logic       prev_en = 1'b0;
  logic [4:0] prev_bit = 5'b0;
  bit         prev_ok = 1'b0;

  // Monitor: invariants every cycle, events matched against the queue.
  always @(negedge Clk) begin
    if (!Reset) begin
      prev_g  = 4'b0;
      prev_ok = 1'b0;
    end else begin
      chk("grant onehot0", int'($onehot0(Grant)), 1);
      chk("bitidx range", int'(int'(BitIdx) <= FB - 1), 1);
      chk("grant implies busy", int'(Grant == 4'b0 || Busy), 1);
      if (prev_ok && prev_g != 4'b0 && Grant != 4'b0)
        chk("bitidx step", int'(BitIdx),
            prev_en ? int'(prev_bit) + 1 : int'(prev_bit));
      if (Grant != 4'b0 && prev_g == 4'b0) begin
        observe(K_GRANT, int'(Grant));
        chk("bitidx at grant", int'(BitIdx), 0);
        if (En) chk("framestart at grant", int'(FrameStart), 1);
      end
      if (Grant == 4'b0 && prev_g != 4'b0) observe(K_FALL, 0);
      if (FrameEnd) observe(K_END, int'(BitIdx));
      if (Aborted) observe(K_ABORT, 0);
      prev_g   = Grant;
      prev_en  = En;
      prev_bit = BitIdx;
      prev_ok  = 1'b1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic drain(input int lim);
    int t0;
    t0 = cyc;
    while (exp_q.size() != 0 && cyc - t0 < lim) tick();
    chk("scoreboard drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_rst();
    chk("reset grant", int'(Grant), 0);
    chk("reset busy", int'(Busy), 0);
    chk("reset bitidx", int'(BitIdx), 0);
    chk("reset aborted", int'(Aborted), 0);
    chk("reset framestart", int'(FrameStart), 0);
    chk("reset frameend", int'(FrameEnd), 0);
  endtask

  task automatic reset_hold(input int n, input logic [3:0] rq);
    tick();
    Reset  = 1'b0;
    Req    = rq;
    en_alt = 1'b0;
    #1;
    chk_rst();
    repeat (n) begin
      tick();
      chk_rst();
    end
    Req   = 4'b0;
    Reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    int r;

    // reset held with every requester asking
    reset_hold(3, 4'b1111);

    // single requester, frame timing and gap
    tick();
    Req = 4'b0010;
    b = cyc;
    frame(2, b + 1, 1'b1);
    push(K_GRANT, 2, b + 24);
    wait_cyc(b + 21);
    chk("gap1 busy", int'(Busy), 1);
    chk("gap1 grant", int'(Grant), 0);
    wait_cyc(b + 22);
    chk("gap2 busy", int'(Busy), 1);
    wait_cyc(b + 23);
    chk("idle busy", int'(Busy), 0);
    chk("idle bitidx", int'(BitIdx), 0);
    wait_cyc(b + 24);
    chk("regrant", int'(Grant), 2);
    drain(60);
    reset_hold(2, 4'b0);

    // full rotation, then two requesters alternating
    tick();
    Req = 4'b1111;
    b = cyc;
    for (int k = 0; k < 5; k++) frame(1 << (k % 4), b + 1 + 23 * k, 1'b1);
    frame(8, b + 1 + 23 * 5, 1'b1);
    frame(1, b + 1 + 23 * 6, 1'b1);
    frame(8, b + 1 + 23 * 7, 1'b0);
    wait_cyc(b + 1 + 23 * 4 + 2);
    Req = 4'b1001;
    drain(300);
    reset_hold(2, 4'b0);

    // bit tick on every other clock
    @(negedge Clk);
    en_base = cyc + 1;
    en_alt  = 1'b1;
    tick();
    Req = 4'b0100;
    b = cyc;
    push(K_GRANT, 4, b + 1);
    push(K_END, FB - 1, b + 39);
    push(K_FALL, 0, b + 40);
    push(K_GRANT, 4, b + 45);
    drain(120);
    reset_hold(2, 4'b0);

    // asynchronous reset mid-frame
    tick();
    Req = 4'b0100;
    b = cyc;
    push(K_GRANT, 4, b + 1);
    wait_cyc(b + 8);
    chk("bitidx before reset", int'(BitIdx), 7);
    Reset = 1'b0;
    #1;
    chk_rst();
    tick();
    chk_rst();
    r = cyc;
    push(K_GRANT, 1, r + 1);
    Req   = 4'b1111;
    Reset = 1'b1;
    drain(40);
    reset_hold(2, 4'b0);

    // winner drops its request mid-frame
    tick();
    Req = 4'b0010;
    b = cyc;
`ifdef SCHED_ABORT_EN
    push(K_GRANT, 2, b + 1);
    push(K_FALL, 0, b + 7);
    push(K_ABORT, 0, b + 7);
    push(K_GRANT, 2, b + 16);
    wait_cyc(b + 6);
    chk("bitidx before drop", int'(BitIdx), 5);
    Req = 4'b0000;
    wait_cyc(b + 7);
    chk("abort pulse", int'(Aborted), 1);
    chk("abort grant", int'(Grant), 0);
    wait_cyc(b + 8);
    chk("abort pulse end", int'(Aborted), 0);
    chk("abort busy", int'(Busy), 1);
    wait_cyc(b + 15);
    Req = 4'b0010;
`else
    frame(2, b + 1, 1'b1);
    push(K_GRANT, 2, b + 31);
    wait_cyc(b + 6);
    chk("bitidx before drop", int'(BitIdx), 5);
    Req = 4'b0000;
    wait_cyc(b + 7);
    chk("drop ignored grant", int'(Grant), 2);
    chk("drop no abort", int'(Aborted), 0);
    wait_cyc(b + 30);
    Req = 4'b0010;
`endif
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
